// File: rtl/and_gate.sv
// Branch-decision gate: combinational PCSrc (zero & branch) plus a registered
// copy of the decision and saturating branch/taken statistics for debug readout.
module and_gate #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             zero,
  input  logic             branch,
  input  logic             instr_valid,
  input  logic             stat_clr,
  output logic             and_out,
  output logic             taken_q,
  output logic [CNT_W-1:0] branch_cnt,
  output logic [CNT_W-1:0] taken_cnt,
  output logic             cnt_sat
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic             taken_d;
  logic [CNT_W-1:0] branch_cnt_q, branch_cnt_d;
  logic [CNT_W-1:0] taken_cnt_q, taken_cnt_d;
  logic             cnt_sat_q, cnt_sat_d;

  // Next-PC select: must stay combinational, independent of clock and reset.
  assign and_out = zero & branch;

  always_comb begin
    taken_d      = taken_q;
    branch_cnt_d = branch_cnt_q;
    taken_cnt_d  = taken_cnt_q;
    cnt_sat_d    = cnt_sat_q;

    if (instr_valid) begin
      taken_d = and_out;
      if (branch && (branch_cnt_q != CNT_MAX)) begin
        branch_cnt_d = branch_cnt_q + CNT_ONE;
      end
      if (and_out && (taken_cnt_q != CNT_MAX)) begin
        taken_cnt_d = taken_cnt_q + CNT_ONE;
      end
    end

    // Sticky flag raised on the same edge a counter lands on all-ones.
    cnt_sat_d = cnt_sat_q | (branch_cnt_d == CNT_MAX) | (taken_cnt_d == CNT_MAX);

    // Clearing statistics overrides increments; the decision register is untouched.
    if (stat_clr) begin
      branch_cnt_d = '0;
      taken_cnt_d  = '0;
      cnt_sat_d    = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      taken_q      <= 1'b0;
      branch_cnt_q <= '0;
      taken_cnt_q  <= '0;
      cnt_sat_q    <= 1'b0;
    end else begin
      taken_q      <= taken_d;
      branch_cnt_q <= branch_cnt_d;
      taken_cnt_q  <= taken_cnt_d;
      cnt_sat_q    <= cnt_sat_d;
    end
  end

  assign branch_cnt = branch_cnt_q;
  assign taken_cnt  = taken_cnt_q;
  assign cnt_sat    = cnt_sat_q;

endmodule

// File: tb/tb_and_gate.sv
// Directed bench for and_gate: a default-width and a 4-bit-counter instance
// driven by the same stimulus, checked against hand-computed values.
module tb_and_gate;

  logic clk = 1'b0;
  logic clk_en = 1'b0;
  logic rst_n = 1'b0;
  logic zero = 1'b0;
  logic branch = 1'b0;
  logic instr_valid = 1'b0;
  logic stat_clr = 1'b0;

  logic        and_out_w, taken_q_w, cnt_sat_w;
  logic [31:0] branch_cnt_w, taken_cnt_w;
  logic        and_out_n, taken_q_n, cnt_sat_n;
  logic [3:0]  branch_cnt_n, taken_cnt_n;

  int vectors = 0;
  int miscompares = 0;

  and_gate #(.CNT_W(32)) u_wide (
    .clk(clk), .rst_n(rst_n), .zero(zero), .branch(branch),
    .instr_valid(instr_valid), .stat_clr(stat_clr),
    .and_out(and_out_w), .taken_q(taken_q_w), .branch_cnt(branch_cnt_w),
    .taken_cnt(taken_cnt_w), .cnt_sat(cnt_sat_w)
  );

  and_gate #(.CNT_W(4)) u_narrow (
    .clk(clk), .rst_n(rst_n), .zero(zero), .branch(branch),
    .instr_valid(instr_valid), .stat_clr(stat_clr),
    .and_out(and_out_n), .taken_q(taken_q_n), .branch_cnt(branch_cnt_n),
    .taken_cnt(taken_cnt_n), .cnt_sat(cnt_sat_n)
  );

  always begin
    #5;
    if (clk_en) clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of inputs on the falling edge, sample 1 ns after the rising edge.
  task automatic step(input logic z, input logic b, input logic v, input logic c);
    @(negedge clk);
    zero = z; branch = b; instr_valid = v; stat_clr = c;
    @(posedge clk);
    #1;
  endtask

  task automatic check_all(input string tag, input logic tq,
                           input logic [31:0] bw, input logic [31:0] tw, input logic sw,
                           input logic [3:0] bn, input logic [3:0] tn, input logic sn);
    check({tag, ".taken_q_w"}, 32'(taken_q_w), 32'(tq));
    check({tag, ".branch_cnt_w"}, branch_cnt_w, bw);
    check({tag, ".taken_cnt_w"}, taken_cnt_w, tw);
    check({tag, ".cnt_sat_w"}, 32'(cnt_sat_w), 32'(sw));
    check({tag, ".taken_q_n"}, 32'(taken_q_n), 32'(tq));
    check({tag, ".branch_cnt_n"}, 32'(branch_cnt_n), 32'(bn));
    check({tag, ".taken_cnt_n"}, 32'(taken_cnt_n), 32'(tn));
    check({tag, ".cnt_sat_n"}, 32'(cnt_sat_n), 32'(sn));
  endtask

  initial begin
    // Reset state, clock idle.
    #1;
    check_all("reset", 1'b0, 32'd0, 32'd0, 1'b0, 4'd0, 4'd0, 1'b0);

    // Truth table with no clock and reset held.
    zero = 1'b0; branch = 1'b0; #1; check("tt00", 32'(and_out_w), 32'd0);
    zero = 1'b0; branch = 1'b1; #1; check("tt01", 32'(and_out_w), 32'd0);
    zero = 1'b1; branch = 1'b0; #1; check("tt10", 32'(and_out_w), 32'd0);
    zero = 1'b1; branch = 1'b1; #1; check("tt11", 32'(and_out_w), 32'd1);
    check("tt11_n", 32'(and_out_n), 32'd1);
    zero = 1'b0; branch = 1'b0;

    // Start clock, release reset away from an edge.
    clk_en = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;

    // Retire 11,01,11,00.
    step(1'b1, 1'b1, 1'b1, 1'b0);
    check_all("ret1", 1'b1, 32'd1, 32'd1, 1'b0, 4'd1, 4'd1, 1'b0);
    step(1'b0, 1'b1, 1'b1, 1'b0);
    check_all("ret2", 1'b0, 32'd2, 32'd1, 1'b0, 4'd2, 4'd1, 1'b0);
    step(1'b1, 1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    check_all("ret4", 1'b0, 32'd3, 32'd2, 1'b0, 4'd3, 4'd2, 1'b0);

    // instr_valid low: everything holds while and_out follows inputs.
    for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 1'b0, 1'b0);
    check_all("hold", 1'b0, 32'd3, 32'd2, 1'b0, 4'd3, 4'd2, 1'b0);
    check("hold.and_out", 32'(and_out_w), 32'd1);

    // Asynchronous reset mid-cycle with nonzero counters.
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_all("async_rst", 1'b0, 32'd0, 32'd0, 1'b0, 4'd0, 4'd0, 1'b0);
    check("async_rst.and_out", 32'(and_out_w), 32'd1);
    branch = 1'b0;
    #1;
    check("async_rst.and_out0", 32'(and_out_w), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Taken-branch saturation on the 4-bit instance.
    for (int i = 0; i < 14; i++) step(1'b1, 1'b1, 1'b1, 1'b0);
    check_all("sat14", 1'b1, 32'd14, 32'd14, 1'b0, 4'd14, 4'd14, 1'b0);
    step(1'b1, 1'b1, 1'b1, 1'b0);
    check_all("sat15", 1'b1, 32'd15, 32'd15, 1'b0, 4'd15, 4'd15, 1'b1);
    step(1'b1, 1'b1, 1'b1, 1'b0);
    check_all("sat16", 1'b1, 32'd16, 32'd16, 1'b0, 4'd15, 4'd15, 1'b1);

    // stat_clr beats the increment and leaves taken_q alone.
    step(1'b1, 1'b1, 1'b1, 1'b1);
    check_all("clr", 1'b1, 32'd0, 32'd0, 1'b0, 4'd0, 4'd0, 1'b0);
    step(1'b0, 1'b1, 1'b1, 1'b0);
    check_all("post_clr", 1'b0, 32'd1, 32'd0, 1'b0, 4'd1, 4'd0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b1);
    check_all("clr_idle", 1'b0, 32'd0, 32'd0, 1'b0, 4'd0, 4'd0, 1'b0);

    // Branch-only saturation: sticky flag from branch_cnt alone.
    for (int i = 0; i < 15; i++) step(1'b0, 1'b1, 1'b1, 1'b0);
    check_all("bsat", 1'b0, 32'd15, 32'd0, 1'b0, 4'd15, 4'd0, 1'b1);
    for (int i = 0; i < 2; i++) step(1'b0, 1'b0, 1'b1, 1'b0);
    check_all("bsat_sticky", 1'b0, 32'd15, 32'd0, 1'b0, 4'd15, 4'd0, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
